// File: rtl/int_entry_sequencer.sv
// Interrupt entry/exit sequencer between the interrupt controller and the VeSPA core.
// Optional vector-fetch timeout is compiled in with `define INT_VEC_TIMEOUT_EN.
module int_entry_sequencer #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] VEC_BASE     = 32'h0000_0000,
    parameter int                VEC_STRIDE   = 4,
    parameter int                TIMEOUT_CYC  = 16,
    parameter logic [ADDR_W-1:0] FALLBACK_VEC = 32'h0000_0100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              int_req,
    input  logic [1:0]        int_number,
    output logic              int_ack_attended,
    output logic              int_ack_complete,
    input  logic              instr_boundary,
    input  logic              reti_exec,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_load_value,
    output logic              cpu_hold,
    output logic              ea_clr,
    output logic              ea_set,
    output logic              vec_rd,
    output logic [ADDR_W-1:0] vec_addr,
    input  logic              vec_ack,
    input  logic [ADDR_W-1:0] vec_data,
    output logic              in_service,
    output logic              fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_FETCH,
        S_LOAD,
        S_SERVICE,
        S_RETURN
    } state_t;

    state_t            state, state_d;
    logic [1:0]        num_q;
    logic [ADDR_W-1:0] saved_pc;
    logic [ADDR_W-1:0] vector_q, vector_d;
    logic [ADDR_W-1:0] vec_addr_d;
    logic              timeout_hit;

    if (TIMEOUT_CYC < 1 || VEC_STRIDE < 1) begin : g_bad_param
        $error("int_entry_sequencer: TIMEOUT_CYC and VEC_STRIDE must be >= 1");
    end

    assign vec_addr_d = VEC_BASE + (ADDR_W'(num_q) * ADDR_W'(VEC_STRIDE));

`ifdef INT_VEC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;

    // Counts FETCH cycles that ended without vec_ack; restarts on every FETCH entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state != S_FETCH) begin
            wait_cnt <= '0;
        end else if (!vec_ack) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == S_FETCH) && !vec_ack &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst) fetch_err <= 1'b0;
        else      fetch_err <= timeout_hit;
    end
`else
    assign timeout_hit = 1'b0;
    assign fetch_err   = 1'b0;
`endif

    always_comb begin
        state_d  = state;
        vector_d = vector_q;
        case (state)
            S_IDLE:    if (int_req && instr_boundary) state_d = S_ACK;
            S_ACK:     state_d = S_FETCH;
            S_FETCH: begin
                // A real acknowledge beats a timeout landing on the same cycle.
                if (vec_ack) begin
                    vector_d = vec_data;
                    state_d  = S_LOAD;
                end else if (timeout_hit) begin
                    vector_d = FALLBACK_VEC;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD:    state_d = S_SERVICE;
            S_SERVICE: if (reti_exec) state_d = S_RETURN;
            S_RETURN:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= S_IDLE;
            num_q            <= '0;
            saved_pc         <= '0;
            vector_q         <= '0;
            int_ack_attended <= 1'b0;
            int_ack_complete <= 1'b0;
            pc_load          <= 1'b0;
            pc_load_value    <= '0;
            cpu_hold         <= 1'b0;
            ea_clr           <= 1'b0;
            ea_set           <= 1'b0;
            vec_rd           <= 1'b0;
            vec_addr         <= '0;
            in_service       <= 1'b0;
        end else begin
            state    <= state_d;
            vector_q <= vector_d;
            if (state == S_IDLE && state_d == S_ACK) begin
                num_q    <= int_number;
                saved_pc <= pc_in;
            end
            if (state == S_ACK) vec_addr <= vec_addr_d;

            int_ack_attended <= (state_d == S_ACK);
            ea_clr           <= (state_d == S_ACK);
            vec_rd           <= (state_d == S_FETCH);
            pc_load          <= (state_d == S_LOAD) || (state_d == S_RETURN);
            in_service       <= (state_d == S_SERVICE);
            ea_set           <= (state_d == S_RETURN);
            int_ack_complete <= (state_d == S_RETURN);
            cpu_hold         <= (state_d == S_ACK) || (state_d == S_FETCH) ||
                                (state_d == S_LOAD) || (state_d == S_RETURN);

            if (state_d == S_LOAD)        pc_load_value <= vector_d;
            else if (state_d == S_RETURN) pc_load_value <= saved_pc;
        end
    end

endmodule

// File: tb/tb_int_entry_sequencer.sv
// Directed bench for int_entry_sequencer; expected values are hand-computed per cycle.
// Build with +define+INT_VEC_TIMEOUT_EN to exercise the fetch timeout path.
module tb_int_entry_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        int_req;
    logic [1:0]  int_number;
    logic        int_ack_attended;
    logic        int_ack_complete;
    logic        instr_boundary;
    logic        reti_exec;
    logic [31:0] pc_in;
    logic        pc_load;
    logic [31:0] pc_load_value;
    logic        cpu_hold;
    logic        ea_clr;
    logic        ea_set;
    logic        vec_rd;
    logic [31:0] vec_addr;
    logic        vec_ack;
    logic [31:0] vec_data;
    logic        in_service;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;

    // Flag order: attended, complete, pc_load, hold, ea_clr, ea_set, vec_rd, in_service, fetch_err
    localparam logic [8:0] F_IDLE    = 9'b000000000;
    localparam logic [8:0] F_ACK     = 9'b100110000;
    localparam logic [8:0] F_FETCH   = 9'b000100100;
    localparam logic [8:0] F_LOAD    = 9'b001100000;
    localparam logic [8:0] F_LOADERR = 9'b001100001;
    localparam logic [8:0] F_SERVICE = 9'b000000010;
    localparam logic [8:0] F_RETURN  = 9'b011101000;

    logic [8:0] flags;
    assign flags = {int_ack_attended, int_ack_complete, pc_load, cpu_hold,
                    ea_clr, ea_set, vec_rd, in_service, fetch_err};

    int_entry_sequencer dut (
        .clk              (clk),
        .rst              (rst),
        .int_req          (int_req),
        .int_number       (int_number),
        .int_ack_attended (int_ack_attended),
        .int_ack_complete (int_ack_complete),
        .instr_boundary   (instr_boundary),
        .reti_exec        (reti_exec),
        .pc_in            (pc_in),
        .pc_load          (pc_load),
        .pc_load_value    (pc_load_value),
        .cpu_hold         (cpu_hold),
        .ea_clr           (ea_clr),
        .ea_set           (ea_set),
        .vec_rd           (vec_rd),
        .vec_addr         (vec_addr),
        .vec_ack          (vec_ack),
        .vec_data         (vec_data),
        .in_service       (in_service),
        .fetch_err        (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic req, input logic bnd, input logic [1:0] num,
                                 input logic [31:0] pc, input logic reti,
                                 input logic ack, input logic [31:0] data);
        int_req        = req;
        instr_boundary = bnd;
        int_number     = num;
        pc_in          = pc;
        reti_exec      = reti;
        vec_ack        = ack;
        vec_data       = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 2'd1, 32'h10, 1'b0, 1'b0, 32'h0);

        // Reset held with a pending request
        for (int i = 0; i < 3; i++) begin
            stepClk();
            checkOutput("reset_flags", 32'(flags), 32'(F_IDLE));
            checkOutput("reset_pcval", pc_load_value, 32'h0);
            checkOutput("reset_vaddr", vec_addr, 32'h0);
        end
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        stepClk();
        checkOutput("idle_after_reset", 32'(flags), 32'(F_IDLE));

        // Basic entry: num 2 at pc 0x40, vector answers in the first FETCH cycle
        applyStimulus(1'b1, 1'b1, 2'd2, 32'h40, 1'b0, 1'b0, 32'h0);
        stepClk();
        checkOutput("basic_ack", 32'(flags), 32'(F_ACK));
        applyStimulus(1'b0, 1'b0, 2'd3, 32'h99, 1'b0, 1'b0, 32'h0);
        stepClk();
        checkOutput("basic_fetch", 32'(flags), 32'(F_FETCH));
        checkOutput("basic_vaddr", vec_addr, 32'h8);
        applyStimulus(1'b0, 1'b0, 2'd3, 32'h99, 1'b0, 1'b1, 32'h200);
        stepClk();
        checkOutput("basic_load", 32'(flags), 32'(F_LOAD));
        checkOutput("basic_pcval", pc_load_value, 32'h200);
        applyStimulus(1'b0, 1'b0, 2'd3, 32'h99, 1'b0, 1'b0, 32'h0);
        stepClk();
        checkOutput("basic_service", 32'(flags), 32'(F_SERVICE));
        checkOutput("pcval_hold", pc_load_value, 32'h200);

        // No nesting: a request during SERVICE is ignored
        applyStimulus(1'b1, 1'b1, 2'd1, 32'h77, 1'b0, 1'b0, 32'h0);
        stepClk();
        checkOutput("nest_ignored", 32'(flags), 32'(F_SERVICE));

        // Return restores 0x40 for exactly one cycle
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 32'h0);
        stepClk();
        checkOutput("return_flags", 32'(flags), 32'(F_RETURN));
        checkOutput("return_pcval", pc_load_value, 32'h40);
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        stepClk();
        checkOutput("after_return", 32'(flags), 32'(F_IDLE));
        checkOutput("after_return_pcval", pc_load_value, 32'h40);

        // Request without an instruction boundary is never taken
        applyStimulus(1'b1, 1'b0, 2'd1, 32'h50, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            stepClk();
            checkOutput("blocked_no_boundary", 32'(flags), 32'(F_IDLE));
        end
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 32'h0);
        stepClk();
        checkOutput("reti_in_idle", 32'(flags), 32'(F_IDLE));

        // Slow vector: ack withheld for 7 FETCH cycles
        applyStimulus(1'b1, 1'b1, 2'd1, 32'h1234, 1'b0, 1'b0, 32'h0);
        stepClk();
        checkOutput("slow_ack", 32'(flags), 32'(F_ACK));
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        stepClk();
        for (int i = 0; i < 7; i++) begin
            checkOutput("slow_fetch", 32'(flags), 32'(F_FETCH));
            checkOutput("slow_vaddr", vec_addr, 32'h4);
            if (i < 6) stepClk();
        end
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 32'h300);
        stepClk();
        checkOutput("slow_load", 32'(flags), 32'(F_LOAD));
        checkOutput("slow_pcval", pc_load_value, 32'h300);
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        stepClk();
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 32'h0);
        stepClk();
        checkOutput("slow_return_pcval", pc_load_value, 32'h1234);
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        stepClk();

        // Reset during FETCH aborts with no pc_load, even with a coincident ack
        applyStimulus(1'b1, 1'b1, 2'd3, 32'h80, 1'b0, 1'b0, 32'h0);
        stepClk();
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        stepClk();
        checkOutput("abort_fetch_vaddr", vec_addr, 32'hC);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 32'h999);
        stepClk();
        checkOutput("abort_flags", 32'(flags), 32'(F_IDLE));
        checkOutput("abort_pcval", pc_load_value, 32'h0);
        checkOutput("abort_vaddr", vec_addr, 32'h0);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        stepClk();
        checkOutput("abort_idle", 32'(flags), 32'(F_IDLE));

        // Vector that never answers
        applyStimulus(1'b1, 1'b1, 2'd0, 32'h10, 1'b0, 1'b0, 32'h0);
        stepClk();
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        stepClk();
`ifdef INT_VEC_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            checkOutput("timeout_wait", 32'(flags), 32'(F_FETCH));
            stepClk();
        end
        checkOutput("timeout_load", 32'(flags), 32'(F_LOADERR));
        checkOutput("timeout_pcval", pc_load_value, 32'h100);
        stepClk();
        checkOutput("timeout_service", 32'(flags), 32'(F_SERVICE));
`else
        for (int i = 0; i < 100; i++) begin
            checkOutput("no_timeout_fetch", 32'(flags), 32'(F_FETCH));
            stepClk();
        end
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b1, 32'h500);
        stepClk();
        checkOutput("late_load", 32'(flags), 32'(F_LOAD));
        checkOutput("late_pcval", pc_load_value, 32'h500);
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        stepClk();
        checkOutput("late_service", 32'(flags), 32'(F_SERVICE));
`endif
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b0, 32'h0);
        stepClk();
        checkOutput("final_return", 32'(flags), 32'(F_RETURN));
        checkOutput("final_return_pcval", pc_load_value, 32'h10);
        applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        stepClk();
        checkOutput("final_idle", 32'(flags), 32'(F_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/int_entry_sequencer.md
Name: int_entry_sequencer

Overview:
- CPU-side interrupt entry/exit sequencer. It sits between the interrupt controller and the VeSPA CPU core.
- Accepts the controller's int_req/int_number at an instruction boundary, returns int_ack_attended, and fetches the handler vector from the vector table over a simple read handshake.
- Redirects the PC to the handler, holds the return PC, and on RETI restores the PC, re-enables interrupts and pulses int_ack_complete.
- Single level: no nesting.

Parameters:
- ADDR_W, 32, width of PC and vector address/data.
- VEC_BASE, 32'h0000_0000, byte address of vector table entry 0.
- VEC_STRIDE, 4, byte spacing between vector entries.
- TIMEOUT_CYC, 16, FETCH wait limit (used only with INT_VEC_TIMEOUT_EN).
- FALLBACK_VEC, 32'h0000_0100, handler address used on fetch timeout.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset (0 = reset)
- int_req  in  1  request from interrupt controller
- int_number  in  2  source index from interrupt controller
- int_ack_attended  out  1  one-cycle pulse: request taken
- int_ack_complete  out  1  one-cycle pulse: handler returned
- instr_boundary  in  1  CPU is between instructions, safe to divert
- reti_exec  in  1  CPU executing RETI (one-cycle pulse)
- pc_in  in  ADDR_W  address of next instruction to execute
- pc_load  out  1  one-cycle strobe: CPU loads pc_load_value
- pc_load_value  out  ADDR_W  new PC
- cpu_hold  out  1  stall CPU fetch/execute
- ea_clr  out  1  one-cycle pulse: clear global interrupt enable
- ea_set  out  1  one-cycle pulse: set global interrupt enable
- vec_rd  out  1  vector read request
- vec_addr  out  ADDR_W  vector read address
- vec_ack  in  1  vector read data valid
- vec_data  in  ADDR_W  vector read data
- in_service  out  1  handler currently executing
- fetch_err  out  1  one-cycle pulse: vector fetch timed out

Behaviour:
- Reset (rst=0 at posedge): state=IDLE. Every output is 0, including pc_load_value and vec_addr. num_q, saved_pc and vector_q are cleared. Reset mid-sequence aborts the sequence with no pc_load and no acks.
- All outputs are registered except vec_addr, which is a registered value held stable.
- IDLE: if int_req && instr_boundary:
  - latch num_q<=int_number and saved_pc<=pc_in;
  - go to ACK.
- ACK (1 cycle): int_ack_attended=1, ea_clr=1, cpu_hold=1; next state FETCH.
- FETCH:
  - vec_rd=1, cpu_hold=1;
  - vec_addr = VEC_BASE + num_q*VEC_STRIDE, computed modulo 2^ADDR_W and constant for the whole state;
  - on vec_ack: vector_q<=vec_data, go to LOAD;
  - vec_ack is allowed in the first FETCH cycle;
  - vec_ack in any other state is ignored.
- LOAD (1 cycle): pc_load=1, pc_load_value=vector_q, cpu_hold=1; next state SERVICE.
- SERVICE:
  - in_service=1, cpu_hold=0;
  - int_req is ignored (no nesting);
  - on reti_exec, go to RETURN.
- RETURN (1 cycle): pc_load=1, pc_load_value=saved_pc, ea_set=1, int_ack_complete=1, cpu_hold=1; next state IDLE.
- Latency:
  - acceptance edge N;
  - int_ack_attended at N+1;
  - first vec_rd at N+2;
  - with vec_ack in that cycle, pc_load at N+3;
  - best case 3 cycles from acceptance to handler PC.
- reti_exec outside SERVICE: ignored.
- int_req deasserted after acceptance: the sequence still completes with the latched num_q.
- int_req held high after RETURN: may be re-accepted on the first IDLE cycle with instr_boundary=1. There is no minimum gap.
- The int_number change rule: only the value latched at acceptance is used.
- Exactly one pulse of int_ack_attended and int_ack_complete per accepted request.
- pc_load_value holds its last value when pc_load=0.

Optional Feature:
- INT_VEC_TIMEOUT_EN defined:
  - a counter clears on FETCH entry and increments each FETCH cycle without vec_ack;
  - when it reaches TIMEOUT_CYC, vector_q<=FALLBACK_VEC, fetch_err pulses 1 cycle, vec_rd drops, and the state goes to LOAD;
  - a vec_ack in the same cycle as the timeout wins, with no fetch_err.
- INT_VEC_TIMEOUT_EN undefined: FETCH waits indefinitely; fetch_err is tied 0; no counter logic.

Test Plan:
- Reset: hold rst=0 for 3 cycles with int_req=1 -> all outputs 0, no ack. Release -> IDLE.
- Basic entry: pc_in=0x40, int_number=2, int_req=instr_boundary=1, vec_ack same cycle as vec_rd with vec_data=0x200 -> pulses and addresses as follows:
  - int_ack_attended and ea_clr at N+1;
  - vec_addr=0x8;
  - pc_load with 0x200 at N+3;
  - in_service=1.
- Return: in SERVICE pulse reti_exec -> next cycle pc_load with 0x40, ea_set=1, int_ack_complete=1, all for exactly 1 cycle. Then IDLE.
- Blocked acceptance and no nesting:
  - int_req=1 with instr_boundary=0 for 5 cycles -> no ack;
  - int_req pulsed during SERVICE -> ignored;
  - reti_exec pulsed in IDLE -> ignored.
- Slow vector and reset: vec_ack delayed 7 cycles -> vec_rd and vec_addr stable for 7 cycles, then LOAD. Reset asserted in FETCH -> IDLE next cycle, no pc_load.
- Timeout (INT_VEC_TIMEOUT_EN, TIMEOUT_CYC=16): no vec_ack -> at the 16th FETCH cycle fetch_err pulses, then pc_load with 0x100. Without the macro -> still in FETCH after 100 cycles.
